uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receive engine: the successor to the fixed 8N1 receiver, which used separate edge-detect, baud-timing and control sub-blocks.
- Integrates input synchroniser, start-edge detect, mid-bit baud timing and frame sequencing in one block.
- Adds configurable data width, parity, stop-bit count, error flags and a valid/ack output handshake.
- Sits between the board Rx pin and the consumer logic (FIFO, command decoder).

Parameters:
- CLKS_PER_BIT, 434, CLK cycles per bit (50 MHz / 115200); legal range ≥ 4.
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.
- SYNC_STAGES, 2, synchroniser flops on Rx_Pin_In; legal ≥ 2.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Rx_En_Sig  input  1  receive enable.
- Rx_Pin_In  input  1  asynchronous serial line; idle high.
- Rx_Ack  input  1  consumer accepts Rx_Data; sampled only while Rx_Valid = 1.
- Rx_Data  output  DATA_BITS  last received payload, LSB = first bit on the wire.
- Rx_Valid  output  1  frame held; stays high until acked.
- Rx_Done_Sig  output  1  one-cycle pulse per completed frame.
- Parity_Err  output  1  parity mismatch on the frame in Rx_Data.
- Frame_Err  output  1  a stop bit sampled low on the frame in Rx_Data.
- Overrun_Err  output  1  sticky; a frame completed while Rx_Valid = 1.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - Synchroniser flops 1.
  - All outputs 0.
  - State IDLE, bit counter 0, baud counter 0.
- Synchroniser: SYNC_STAGES flops. Falling edge = previous synced bit 1, current synced bit 0; call that cycle t0.
- State machine: IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE.
- Baud counter: runs from 0 to its target and restarts at 0 in the sample cycle. Target is CLKS_PER_BIT/2-1 (integer divide) in START, CLKS_PER_BIT-1 in every other state.
- Sample instants:
  - Start bit at t0 + CLKS_PER_BIT/2.
  - Each later bit one CLKS_PER_BIT after the previous sample.
- IDLE: leave on a falling edge only when Rx_En_Sig = 1.
- START: if the start sample is 1, it is a false start; return to IDLE with no output change.
- DATA: shift in DATA_BITS samples, LSB first.
- PARITY: compare the sample against the XOR of the data bits.
  - Odd: expected = ~XOR.
  - Even: expected = XOR.
- STOP:
  - Sample STOP_BITS bits; any 0 sets a frame-error flag internal to the frame.
  - On the last stop sample, return to IDLE immediately. This allows re-arm within the remaining half stop bit.
- Completion, the cycle after the last stop sample:
  - Rx_Data, Parity_Err and Frame_Err are loaded.
  - Rx_Done_Sig = 1 for exactly one cycle; Rx_Valid <= 1.
  - Frames with errors are still delivered; the flags qualify them.
- Rx_Data and the error flags hold their values until the next completion or RST. No clearing on disable.
- Handshake:
  - Rx_Ack = 1 while Rx_Valid = 1 clears Rx_Valid on the next cycle.
  - Completion and Ack in the same cycle: completion wins, Rx_Valid stays 1, no overrun.
  - Completion while Rx_Valid = 1 and no Ack: new data overwrites and Overrun_Err <= 1.
- Overrun_Err clears only on RST.
- Rx_En_Sig low mid-frame: abort to IDLE on the next cycle. No completion and no output change. Counters are zeroed.
- Line held low while in IDLE: no new frame starts until a fresh 1 -> 0 edge appears.
- RST mid-frame: immediate return to reset values. The partial frame is discarded.
- Width rules:
  - Baud counter width is clog2(CLKS_PER_BIT).
  - Bit counter width is clog2(DATA_BITS+1).
  - With DATA_BITS = 9 the output is 9 bits, with no truncation.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 -> Rx_Data=0xA5; Rx_Done_Sig pulse 1 cycle after the stop sample (t0+152 cycles); Rx_Valid=1; no errors.
- Glitch low for 5 cycles on the line -> START false-start; Busy returns low by t0+9; no Rx_Done_Sig; Rx_Data unchanged.
- PARITY=2, send 0x03 with parity bit 1 -> Parity_Err=1, Rx_Data=0x03. Resend with parity 0 -> Parity_Err=0.
- STOP_BITS=2, send 0x55 with second stop bit 0 -> Frame_Err=1, Rx_Data=0x55, Rx_Done_Sig still pulses.
- Two back-to-back frames 0x11 then 0x22, no Rx_Ack -> Rx_Data=0x22, Overrun_Err=1 sticky. Third frame with Ack asserted in its completion cycle -> Rx_Valid stays 1.
- Rx_En_Sig dropped during data bit 3 -> Busy low next cycle, no completion. RST asserted mid-frame -> all outputs 0; next frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: input synchroniser, start-edge detect, mid-bit sampling,
// optional parity, one or two stop bits, error flags and a valid/ack output handshake.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Rx_En_Sig,
  input  logic                 Rx_Pin_In,
  input  logic                 Rx_Ack,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic                 Rx_Done_Sig,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Overrun_Err,
  output logic                 Busy
);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] HALF_TGT  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_TGT  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  state_t                 r_state;
  logic [BAUD_W-1:0]      r_baud;
  logic [BIT_W-1:0]       r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_f;
  logic                   r_frm_f;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_done;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_ovr;
  logic                   r_busy;

  logic                   w_rx;
  logic                   w_fall;
  logic                   w_tick;
  logic                   w_par_exp;
  logic                   w_frm_acc;

  assign w_rx      = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_prev & ~w_rx;
  assign w_tick    = (r_baud == ((r_state == S_START) ? HALF_TGT : FULL_TGT));
  assign w_par_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
  assign w_frm_acc = r_frm_f | ~w_rx;

  // Metastability guard on the asynchronous line; idles high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Rx_Pin_In};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev   <= 1'b1;
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par_f  <= 1'b0;
      r_frm_f  <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_prev <= w_rx;
      r_done <= 1'b0;
      if (r_valid && Rx_Ack) begin
        r_valid <= 1'b0;
      end
      if (!Rx_En_Sig && (r_state != S_IDLE)) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_baud   <= '0;
        r_bitcnt <= '0;
      end else if (r_state == S_IDLE) begin
        r_baud   <= '0;
        r_bitcnt <= '0;
        if (Rx_En_Sig && w_fall) begin
          r_state <= S_START;
          r_busy  <= 1'b1;
          r_par_f <= 1'b0;
          r_frm_f <= 1'b0;
        end
      end else begin
        r_baud <= w_tick ? '0 : (r_baud + BAUD_W'(1));
        if (w_tick) begin
          case (r_state)
            S_START: begin
              // A high start sample means the edge was a glitch.
              if (w_rx) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end
            S_DATA: begin
              r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
              if (r_bitcnt == LAST_DATA) begin
                r_bitcnt <= '0;
                r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                r_bitcnt <= r_bitcnt + BIT_W'(1);
              end
            end
            S_PARITY: begin
              r_par_f <= (w_rx != w_par_exp);
              r_state <= S_STOP;
            end
            S_STOP: begin
              if (r_bitcnt == LAST_STOP) begin
                // Leave mid stop bit so the next start edge can be caught.
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_bitcnt <= '0;
                r_data   <= r_shift;
                r_perr   <= r_par_f;
                r_ferr   <= w_frm_acc;
                r_done   <= 1'b1;
                r_valid  <= 1'b1;
                if (r_valid && !Rx_Ack) begin
                  r_ovr <= 1'b1;
                end
              end else begin
                r_frm_f  <= w_frm_acc;
                r_bitcnt <= r_bitcnt + BIT_W'(1);
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign Rx_Data     = r_data;
  assign Rx_Valid    = r_valid;
  assign Rx_Done_Sig = r_done;
  assign Parity_Err  = r_perr;
  assign Frame_Err   = r_ferr;
  assign Overrun_Err = r_ovr;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven with directed and random frames,
// compared against a frame-level model built from bit lists and sample-time arithmetic.
`timescale 1ns/1ps
module tb_uart_rx_param;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] en, pin, ack;
  logic [2:0] valid, done, perr, ferr, ovr, busy;
  logic [7:0] d0, d1;
  logic [8:0] d2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt [3];
  int done_cyc [3];

  logic [8:0] m_data  [3];
  bit         m_valid [3];
  bit         m_perr  [3];
  bit         m_ferr  [3];
  bit         m_ovr   [3];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_dut0 (
    .CLK(clk), .RST(rst), .Rx_En_Sig(en[0]), .Rx_Pin_In(pin[0]), .Rx_Ack(ack[0]),
    .Rx_Data(d0), .Rx_Valid(valid[0]), .Rx_Done_Sig(done[0]), .Parity_Err(perr[0]),
    .Frame_Err(ferr[0]), .Overrun_Err(ovr[0]), .Busy(busy[0]));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)) u_dut1 (
    .CLK(clk), .RST(rst), .Rx_En_Sig(en[1]), .Rx_Pin_In(pin[1]), .Rx_Ack(ack[1]),
    .Rx_Data(d1), .Rx_Valid(valid[1]), .Rx_Done_Sig(done[1]), .Parity_Err(perr[1]),
    .Frame_Err(ferr[1]), .Overrun_Err(ovr[1]), .Busy(busy[1]));

  uart_rx_param #(.CLKS_PER_BIT(7), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(3)) u_dut2 (
    .CLK(clk), .RST(rst), .Rx_En_Sig(en[2]), .Rx_Pin_In(pin[2]), .Rx_Ack(ack[2]),
    .Rx_Data(d2), .Rx_Valid(valid[2]), .Rx_Done_Sig(done[2]), .Parity_Err(perr[2]),
    .Frame_Err(ferr[2]), .Overrun_Err(ovr[2]), .Busy(busy[2]));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
    end
  end

  function automatic int cpb(input int i);
    return (i == 2) ? 7 : 16;
  endfunction
  function automatic int nbits(input int i);
    return (i == 2) ? 9 : 8;
  endfunction
  function automatic int pmode(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int nstop(input int i);
    return (i == 1) ? 2 : 1;
  endfunction
  function automatic int nsync(input int i);
    return (i == 2) ? 3 : 2;
  endfunction

  function automatic logic [8:0] get_data(input int i);
    case (i)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs(input int i, input string tag);
    chk($sformatf("%s.u%0d.data", tag, i), 32'(get_data(i)), 32'(m_data[i]));
    chk($sformatf("%s.u%0d.valid", tag, i), 32'(valid[i]), 32'(m_valid[i]));
    chk($sformatf("%s.u%0d.perr", tag, i), 32'(perr[i]), 32'(m_perr[i]));
    chk($sformatf("%s.u%0d.ferr", tag, i), 32'(ferr[i]), 32'(m_ferr[i]));
    chk($sformatf("%s.u%0d.ovr", tag, i), 32'(ovr[i]), 32'(m_ovr[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_data[i] = '0; m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
    end
  endtask

  // Drive one full frame; optionally assert Rx_Ack on the completing edge.
  task automatic send_frame(input int i, input logic [8:0] d, input bit bad_par,
                            input logic [1:0] stops, input bit ack_done);
    int c, n, last, c0, cnt0;
    logic [8:0] dm;
    bit bits[$];
    bit p, fe;
    c  = cpb(i);
    dm = d & 9'((1 << nbits(i)) - 1);
    bits.push_back(1'b0);
    for (int j = 0; j < nbits(i); j++) bits.push_back(dm[j]);
    if (pmode(i) != 0) begin
      p = ^dm;
      if (pmode(i) == 1) p = ~p;
      bits.push_back(p ^ bad_par);
    end
    fe = 0;
    for (int j = 0; j < nstop(i); j++) begin
      bits.push_back(stops[j]);
      if (!stops[j]) fe = 1;
    end
    n    = bits.size();
    last = nsync(i) + c / 2 + c * (n - 1);
    cnt0 = done_cnt[i];
    @(negedge clk);
    c0 = cyc;
    for (int k = 0; k < n * c; k++) begin
      pin[i] = bits[k / c];
      ack[i] = ack_done && (k == last);
      @(negedge clk);
    end
    pin[i] = 1'b1;
    ack[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    m_ovr[i]   = m_ovr[i] | (m_valid[i] & ~ack_done);
    m_valid[i] = 1;
    m_data[i]  = dm;
    m_perr[i]  = (pmode(i) != 0) && bad_par;
    m_ferr[i]  = fe;
    chk($sformatf("frame.u%0d.done_count", i), 32'(done_cnt[i] - cnt0), 32'd1);
    chk($sformatf("frame.u%0d.done_cycle", i), 32'(done_cyc[i] - c0), 32'(1 + last));
    chk($sformatf("frame.u%0d.busy", i), 32'(busy[i]), 32'd0);
    chk_outputs(i, "frame");
  endtask

  task automatic ack_pulse(input int i);
    @(negedge clk);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
    m_valid[i] = 0;
    chk($sformatf("ack.u%0d.valid", i), 32'(valid[i]), 32'd0);
  endtask

  // Short low pulse: start sample sees high again, so nothing is delivered.
  task automatic glitch(input int i, input int len);
    int c, cnt0;
    c    = cpb(i);
    cnt0 = done_cnt[i];
    @(negedge clk);
    for (int k = 0; k < 2 * c; k++) begin
      pin[i] = (k < len) ? 1'b0 : 1'b1;
      if (k == len - 1) chk($sformatf("glitch.u%0d.busy_hi", i), 32'(busy[i]), 32'd1);
      if (k == nsync(i) + c / 2 + 1) chk($sformatf("glitch.u%0d.busy_lo", i), 32'(busy[i]), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("glitch.u%0d.no_done", i), 32'(done_cnt[i] - cnt0), 32'd0);
    chk_outputs(i, "glitch");
  endtask

  // Start a frame, then drop the enable part way through a data bit.
  task automatic en_drop(input int i, input logic [8:0] d, input int kdrop);
    int c, cnt0, b;
    c    = cpb(i);
    cnt0 = done_cnt[i];
    @(negedge clk);
    for (int k = 0; k <= kdrop; k++) begin
      b = k / c;
      pin[i] = (b == 0) ? 1'b0 : d[b - 1];
      if (k == kdrop) begin
        chk($sformatf("endrop.u%0d.busy_before", i), 32'(busy[i]), 32'd1);
        en[i] = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("endrop.u%0d.busy_after", i), 32'(busy[i]), 32'd0);
    pin[i] = 1'b1;
    repeat (3 * c) @(negedge clk);
    en[i] = 1'b1;
    repeat (c) @(negedge clk);
    chk($sformatf("endrop.u%0d.no_done", i), 32'(done_cnt[i] - cnt0), 32'd0);
    chk_outputs(i, "endrop");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    int i;
    rst = 1'b1;
    en  = 3'b111;
    pin = 3'b111;
    ack = 3'b000;
    for (int k = 0; k < 3; k++) begin
      done_cnt[k] = 0;
      done_cyc[k] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_outputs(k, "reset");
      chk($sformatf("reset.u%0d.done_busy", k), 32'({done[k], busy[k]}), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(0, 9'h0A5, 0, 2'b11, 0);
    glitch(0, 5);

    ack_pulse(1);
    send_frame(1, 9'h003, 1, 2'b11, 0);
    ack_pulse(1);
    send_frame(1, 9'h003, 0, 2'b11, 0);
    ack_pulse(1);
    send_frame(1, 9'h055, 0, 2'b01, 0);
    send_frame(1, 9'h066, 0, 2'b11, 1);

    ack_pulse(0);
    send_frame(0, 9'h011, 0, 2'b11, 0);
    send_frame(0, 9'h022, 0, 2'b11, 0);
    send_frame(0, 9'h033, 0, 2'b11, 1);

    en_drop(0, 9'h0C3, 4 * 16 + 8);

    // Reset in the middle of a frame on u1.
    @(negedge clk);
    pin[1] = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstmid.u1.busy_before", 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk_outputs(k, "rstmid");
      chk($sformatf("rstmid.u%0d.busy", k), 32'(busy[k]), 32'd0);
    end
    pin[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(0, 9'h07E, 0, 2'b11, 0);
    send_frame(1, 9'h0E7, 0, 2'b11, 0);

    // Line already low when enable rises: no frame without a fresh edge.
    cnt0 = done_cnt[2];
    en[2] = 1'b0;
    @(negedge clk);
    pin[2] = 1'b0;
    repeat (10) @(negedge clk);
    en[2] = 1'b1;
    repeat (30) @(negedge clk);
    chk("idlelow.u2.busy", 32'(busy[2]), 32'd0);
    pin[2] = 1'b1;
    repeat (5) @(negedge clk);
    chk("idlelow.u2.no_done", 32'(done_cnt[2] - cnt0), 32'd0);
    send_frame(2, 9'h1A7, 0, 2'b11, 0);

    for (int t = 0; t < 36; t++) begin
      i = int'($urandom_range(2, 0));
      if ($urandom_range(1, 0) == 1) ack_pulse(i);
      send_frame(i, 9'($urandom), ($urandom_range(3, 0) == 0),
                 ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b11,
                 ($urandom_range(3, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
